id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/fwd_mux.sv | 32 +++
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants: ALU op encodings, operand-select encodings, default XLEN.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package riscv_pkg;

    localparam int XLEN = 32;

    // ALU operation encodings carried from decode to execute.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    // Operand A / B source selects.
    localparam logic A_SEL_RS1 = 1'b0;
    localparam logic A_SEL_PC  = 1'b1;
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    // A later-stage write targets this source register. x0 is hardwired
    // zero, so a write "to x0" must never be treated as a producer.
    function automatic logic fwd_hit(
        input logic       reg_write,
        input logic [4:0] rd,
        input logic [4:0] addr
    );
        return reg_write && (rd != 5'd0) && (rd == addr);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result, else MEM/WB result, else the stored register value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
//
// Ports: addr/stored_data = source register index and value held in ID/EX;
//        exmem_* / memwb_* = the two forwarding producers; fwd_data = selected operand.
module fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] stored_data,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] fwd_data
);
    import riscv_pkg::*;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        fwd_data = stored_data;
        if (fwd_hit(exmem_reg_write, exmem_rd, addr)) begin
            fwd_data = exmem_result;
        end else if (fwd_hit(memwb_reg_write, memwb_rd, addr)) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU operand and store-data paths.
// Latency: one cycle from in_* to outputs; forwarding adds no cycles.
// Backpressure: stall holds contents (refreshing operands from MEM/WB), flush kills; flush > stall > capture.
//
// Ports: in_* = decoded instruction; stall/flush = hazard control;
//        exmem_* / memwb_* = forwarding sources; ex_valid, alu_a, alu_b, alu_control,
//        ex_rd, ex_reg_write, ex_store_data = execute-stage view of the held instruction.
module id_ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [3:0]      in_alu_control,
    input  logic            in_a_sel,
    input  logic            in_b_sel,
    input  logic            in_reg_write,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_store_data
);
    import riscv_pkg::*;

    logic            valid_q,       valid_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic [XLEN-1:0] rs1_data_q,    rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,    rs2_data_d;
    logic [XLEN-1:0] imm_q,         imm_d;
    logic [4:0]      rs1_addr_q,    rs1_addr_d;
    logic [4:0]      rs2_addr_q,    rs2_addr_d;
    logic [4:0]      rd_q,          rd_d;
    logic [3:0]      alu_control_q, alu_control_d;
    logic            a_sel_q,       a_sel_d;
    logic            b_sel_q,       b_sel_d;
    logic            reg_write_q,   reg_write_d;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    always_comb begin
        valid_d       = valid_q;
        pc_d          = pc_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        rs1_addr_d    = rs1_addr_q;
        rs2_addr_d    = rs2_addr_q;
        rd_d          = rd_q;
        alu_control_d = alu_control_q;
        a_sel_d       = a_sel_q;
        b_sel_d       = b_sel_q;
        reg_write_d   = reg_write_q;

        if (flush) begin
            // Only the qualifiers need clearing; the rest is dead data.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (stall) begin
            // The MEM/WB producer retires while we wait; once it is gone no
            // forwarding path can supply it, so absorb its result now.
            if (fwd_hit(memwb_reg_write, memwb_rd, rs1_addr_q)) begin
                rs1_data_d = memwb_result;
            end
            if (fwd_hit(memwb_reg_write, memwb_rd, rs2_addr_q)) begin
                rs2_data_d = memwb_result;
            end
        end else begin
            valid_d       = in_valid;
            pc_d          = in_pc;
            rs1_data_d    = in_rs1_data;
            rs2_data_d    = in_rs2_data;
            imm_d         = in_imm;
            rs1_addr_d    = in_rs1_addr;
            rs2_addr_d    = in_rs2_addr;
            rd_d          = in_rd_addr;
            alu_control_d = in_alu_control;
            a_sel_d       = in_a_sel;
            b_sel_d       = in_b_sel;
            reg_write_d   = in_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rs1_addr_q    <= 5'd0;
            rs2_addr_q    <= 5'd0;
            rd_q          <= 5'd0;
            alu_control_q <= ALU_ADD;
            a_sel_q       <= A_SEL_RS1;
            b_sel_q       <= B_SEL_RS2;
            reg_write_q   <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rd_q          <= rd_d;
            alu_control_q <= alu_control_d;
            a_sel_q       <= a_sel_d;
            b_sel_q       <= b_sel_d;
            reg_write_q   <= reg_write_d;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .addr            (rs1_addr_q),
        .stored_data     (rs1_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .addr            (rs2_addr_q),
        .stored_data     (rs2_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (rs2_fwd)
    );

    assign ex_valid      = valid_q;
    assign alu_a         = (a_sel_q == A_SEL_PC)  ? pc_q  : rs1_fwd;
    assign alu_b         = (b_sel_q == B_SEL_IMM) ? imm_q : rs2_fwd;
    assign alu_control   = alu_control_q;
    assign ex_rd         = rd_q;
    // Store data is always the register operand, even when B takes the immediate.
    assign ex_store_data = rs2_fwd;
    assign ex_reg_write  = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model of the held instruction plus directed literals.
// Latency: checks outputs one cycle after capture, forwarding checked combinationally.
// Backpressure: exercises stall hold/refresh, flush, flush+stall and async reset.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]  in_alu_control;
    logic        in_a_sel, in_b_sel, in_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_alu_control(in_alu_control), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_reg_write(in_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data)
    );

    // Reference: the instruction the execute stage currently owns.
    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic [3:0]  op;
        logic        asel, bsel, rw;
    } instr_t;

    instr_t m;

    // Value a register read must return right now, seen from execute.
    function automatic logic [31:0] reg_value(input logic [4:0] a, input logic [31:0] held);
        if (a == 5'd0) return held;
        if (exmem_reg_write && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd == a) return memwb_result;
        return held;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{valid: 1'b0, pc: 32'd0, rs1: 32'd0, rs2: 32'd0, imm: 32'd0,
                   rs1a: 5'd0, rs2a: 5'd0, rd: 5'd0, op: 4'd0, asel: 1'b0, bsel: 1'b0, rw: 1'b0};
        end else if (flush) begin
            m.valid <= 1'b0;
            m.rw    <= 1'b0;
        end else if (stall) begin
            if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rs1a) m.rs1 <= memwb_result;
            if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rs2a) m.rs2 <= memwb_result;
        end else begin
            m <= '{valid: in_valid, pc: in_pc, rs1: in_rs1_data, rs2: in_rs2_data, imm: in_imm,
                   rs1a: in_rs1_addr, rs2a: in_rs2_addr, rd: in_rd_addr, op: in_alu_control,
                   asel: in_a_sel, bsel: in_b_sel, rw: in_reg_write};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare on every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("m.ex_valid",      {31'd0, ex_valid},     {31'd0, m.valid});
        chk("m.ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, m.rw & m.valid});
        chk("m.alu_control",   {28'd0, alu_control},  {28'd0, m.op});
        chk("m.ex_rd",         {27'd0, ex_rd},        {27'd0, m.rd});
        chk("m.alu_a",         alu_a,         m.asel ? m.pc  : reg_value(m.rs1a, m.rs1));
        chk("m.alu_b",         alu_b,         m.bsel ? m.imm : reg_value(m.rs2a, m.rs2));
        chk("m.ex_store_data", ex_store_data, reg_value(m.rs2a, m.rs2));
    end

    task automatic set_in(input logic [31:0] pc, input logic [4:0] r1a, input logic [31:0] r1d,
                          input logic [4:0] r2a, input logic [31:0] r2d, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [3:0] op, input logic asel,
                          input logic bsel, input logic rw, input logic vld);
        in_pc = pc; in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a; in_rs2_data = r2d;
        in_imm = imm; in_rd_addr = rd; in_alu_control = op; in_a_sel = asel; in_b_sel = bsel;
        in_reg_write = rw; in_valid = vld;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    // One clock edge, then settle to just after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        no_fwd();
        set_in(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk("rst.ex_valid",     {31'd0, ex_valid},     32'd0);
        chk("rst.ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("rst.alu_control",  {28'd0, alu_control},  32'd0);
        chk("rst.ex_rd",        {27'd0, ex_rd},        32'd0);

        // Plain capture, SUB.
        set_in(32'h100, 5'd1, 32'd5, 5'd2, 32'd3, 32'h40, 5'd3, ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        chk("cap.alu_a",        alu_a,                 32'd5);
        chk("cap.alu_b",        alu_b,                 32'd3);
        chk("cap.alu_control",  {28'd0, alu_control},  32'h1);
        chk("cap.ex_valid",     {31'd0, ex_valid},     32'd1);
        chk("cap.ex_reg_write", {31'd0, ex_reg_write}, 32'd1);
        chk("cap.ex_rd",        {27'd0, ex_rd},        32'd3);

        // Double forward on rs1=7: EX/MEM beats MEM/WB.
        set_in(32'h200, 5'd7, 32'h11, 5'd8, 32'h22, 32'h0, 5'd5, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        stall = 1'b1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_result = 32'hBB;
        #1 chk("fwd.exmem_wins", alu_a, 32'hAA);
        exmem_reg_write = 1'b0;
        #1 chk("fwd.memwb",      alu_a, 32'hBB);
        no_fwd();
        #1 chk("fwd.none",       alu_a, 32'h11);
        stall = 1'b0;

        // x0 is never forwarded.
        set_in(32'h300, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd1, ALU_AND, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hEE;
        #1 chk("x0.alu_a", alu_a, 32'd0);
        chk("x0.store", ex_store_data, 32'd0);
        no_fwd();

        // Stall refresh of rs2=4 from a retiring MEM/WB write.
        set_in(32'h400, 5'd2, 32'h5, 5'd4, 32'h99, 32'h77, 5'd6, ALU_OR, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc();
        stall = 1'b1;
        set_in(32'hBAD, 5'd9, 32'hBAD, 5'd9, 32'hBAD, 32'hBAD, 5'd9, ALU_SRA, 1'b1, 1'b0, 1'b0, 1'b1);
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h1234;
        cyc();
        no_fwd();
        cyc();
        stall = 1'b0;
        #1;
        chk("refresh.store", ex_store_data, 32'h1234);
        chk("refresh.alu_b", alu_b,         32'h77);
        chk("refresh.ex_rd", {27'd0, ex_rd}, 32'd6);

        // Flush and stall on the same edge: flush wins.
        set_in(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd10, ALU_SLT, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        chk("pre_flush.ex_valid", {31'd0, ex_valid}, 32'd1);
        flush = 1'b1; stall = 1'b1;
        cyc();
        chk("flush.ex_valid",     {31'd0, ex_valid},     32'd0);
        chk("flush.ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Asynchronous reset mid-stall, between edges.
        set_in(32'h600, 5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 32'h8, 5'd9, ALU_XOR, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        chk("pre_rst.ex_valid", {31'd0, ex_valid}, 32'd1);
        stall = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("arst.ex_valid",     {31'd0, ex_valid},     32'd0);
        chk("arst.ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("arst.alu_control",  {28'd0, alu_control},  32'd0);
        chk("arst.ex_rd",        {27'd0, ex_rd},        32'd0);
        chk("arst.alu_a",        alu_a,                 32'd0);
        stall = 1'b0;
        #1 rst_n = 1'b1;
        cyc();
        chk("post_rst.ex_valid", {31'd0, ex_valid},    32'd1);
        chk("post_rst.ex_rd",    {27'd0, ex_rd},       32'd9);
        chk("post_rst.alu_a",    alu_a,                32'hDEAD);

        // Directed sweep of selects, forwarding hits and hazard controls.
        for (int i = 0; i < 24; i++) begin
            logic [4:0] a1, a2;
            a1 = 5'(i % 4);
            a2 = 5'((i + 1) % 4);
            set_in(32'h1000 + 32'(i * 4), a1, 32'h100 + 32'(i), a2, 32'h200 + 32'(i),
                   32'h300 + 32'(i), 5'(i), 4'(i % 12), i[0], i[1], i[2], (i % 6) != 5);
            exmem_reg_write = (i % 3) == 0; exmem_rd = 5'(i % 4); exmem_result = 32'hE000 + 32'(i);
            memwb_reg_write = (i % 2) == 0; memwb_rd = 5'((i + 1) % 4); memwb_result = 32'hA000 + 32'(i);
            stall = (i % 5) == 3;
            flush = (i % 7) == 6;
            cyc();
        end
        stall = 1'b0; flush = 1'b0; no_fwd();
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
